// File: rtl/muldiv_sequencer.sv
// HI/LO owner: radix-2 shift-add multiply / restoring divide beside the ALU; divide path only when MULDIV_DIV_EN is defined.
// Latency: mul/div results land 33 cycles after the start edge, zero divisor after 2, MTHI/MTLO after 1.
// Backpressure: o_Stall holds any HI/LO-touching instruction while busy; a start while busy is ignored.
module muldiv_sequencer #(
    parameter int NBITS  = 32,
    parameter int FNBITS = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_Start,
    input  logic              i_Req,
    input  logic              i_Flush,
    input  logic [FNBITS-1:0] i_Funct,
    input  logic [NBITS-1:0]  i_A,
    input  logic [NBITS-1:0]  i_B,
    output logic              o_Busy,
    output logic              o_Stall,
    output logic              o_Done,
    output logic              o_DivZero,
    output logic [NBITS-1:0]  o_HI,
    output logic [NBITS-1:0]  o_LO,
    output logic [NBITS-1:0]  o_Result
);
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    localparam logic [FNBITS-1:0] F_MULT  = FNBITS'(6'b011000);
    localparam logic [FNBITS-1:0] F_MULTU = FNBITS'(6'b011001);
    localparam logic [FNBITS-1:0] F_MFHI  = FNBITS'(6'b010000);
    localparam logic [FNBITS-1:0] F_MTHI  = FNBITS'(6'b010001);
    localparam logic [FNBITS-1:0] F_MTLO  = FNBITS'(6'b010011);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [NBITS-1:0]   p_hi, p_lo, opnd, hi, lo;
    logic               sa, sb, done;

    logic               sign_a, sign_b, is_mul_f;
    logic [NBITS-1:0]   abs_a, abs_b;
    logic [NBITS:0]     mul_sum;
    logic [2*NBITS-1:0] prod, prod_fix;

`ifdef MULDIV_DIV_EN
    localparam logic [FNBITS-1:0] F_DIV  = FNBITS'(6'b011010);
    localparam logic [FNBITS-1:0] F_DIVU = FNBITS'(6'b011011);

    logic               is_div, dz, divzero, is_div_f, trial_ok;
    logic [NBITS:0]     rem_sh, trial;
    logic [NBITS-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_div_f = (i_Funct == F_DIV) || (i_Funct == F_DIVU);
        rem_sh   = {p_hi, p_lo[NBITS-1]};
        trial    = rem_sh - {1'b0, opnd};
        // rem_sh < 2*divisor, so a set top bit already means the subtract fits
        trial_ok = rem_sh[NBITS] | ~trial[NBITS];
        quo_fix  = (sa ^ sb) ? -p_lo : p_lo;
        rem_fix  = sa ? -p_hi : p_hi;
    end

    assign o_DivZero = divzero;
`else
    assign o_DivZero = 1'b0;
`endif

    always_comb begin
        // MULT and DIV have funct[0] = 0; their unsigned twins have it set
        sign_a   = ~i_Funct[0] & i_A[NBITS-1];
        sign_b   = ~i_Funct[0] & i_B[NBITS-1];
        abs_a    = sign_a ? -i_A : i_A;
        abs_b    = sign_b ? -i_B : i_B;
        is_mul_f = (i_Funct == F_MULT) || (i_Funct == F_MULTU);
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
        prod     = {p_hi, p_lo};
        prod_fix = (sa ^ sb) ? -prod : prod;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            opnd    <= '0;
            hi      <= '0;
            lo      <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            done    <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            dz      <= 1'b0;
            divzero <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
`ifdef MULDIV_DIV_EN
            divzero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_Start && !i_Flush) begin
                        if (i_Funct == F_MTHI) begin
                            hi <= i_A;
                        end else if (i_Funct == F_MTLO) begin
                            lo <= i_A;
                        end else if (is_mul_f) begin
                            p_hi  <= '0;
                            p_lo  <= abs_b;
                            opnd  <= abs_a;
                            sa    <= sign_a;
                            sb    <= sign_b;
                            cnt   <= '0;
                            state <= RUN;
`ifdef MULDIV_DIV_EN
                            is_div <= 1'b0;
                            dz     <= 1'b0;
                        end else if (is_div_f) begin
                            is_div <= 1'b1;
                            sa     <= sign_a;
                            sb     <= sign_b;
                            if (i_B == '0) begin
                                // raw dividend goes to HI; FIX waits one extra cycle on cnt
                                dz    <= 1'b1;
                                p_hi  <= i_A;
                                cnt   <= CW'(1);
                                state <= FIX;
                            end else begin
                                dz    <= 1'b0;
                                p_hi  <= '0;
                                p_lo  <= abs_a;
                                opnd  <= abs_b;
                                cnt   <= '0;
                                state <= RUN;
                            end
`endif
                        end
                    end
                end
                RUN: begin
                    if (i_Flush) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            p_hi <= trial_ok ? trial[NBITS-1:0] : rem_sh[NBITS-1:0];
                            p_lo <= {p_lo[NBITS-2:0], trial_ok};
                        end else
`endif
                        begin
                            p_hi <= mul_sum[NBITS:1];
                            p_lo <= {mul_sum[0], p_lo[NBITS-1:1]};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (i_Flush) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= '0;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (dz) begin
                            hi <= p_hi;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else
`endif
                        begin
                            hi <= prod_fix[2*NBITS-1:NBITS];
                            lo <= prod_fix[NBITS-1:0];
                        end
`ifdef MULDIV_DIV_EN
                        divzero <= dz;
`endif
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Busy   = (state != IDLE);
    assign o_Stall  = i_Req & o_Busy;
    assign o_Done   = done;
    assign o_HI     = hi;
    assign o_LO     = lo;
    assign o_Result = (i_Funct == F_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer; divide vectors apply when MULDIV_DIV_EN is defined.
module tb_muldiv_sequencer;
    localparam int NBITS  = 32;
    localparam int FNBITS = 6;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic              i_clk = 1'b0;
    logic              i_rst_n, i_Start, i_Req, i_Flush;
    logic [FNBITS-1:0] i_Funct;
    logic [NBITS-1:0]  i_A, i_B;
    logic              o_Busy, o_Stall, o_Done, o_DivZero;
    logic [NBITS-1:0]  o_HI, o_LO, o_Result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_sequencer #(.NBITS(NBITS), .FNBITS(FNBITS)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_Start   (i_Start),
        .i_Req     (i_Req),
        .i_Flush   (i_Flush),
        .i_Funct   (i_Funct),
        .i_A       (i_A),
        .i_B       (i_B),
        .o_Busy    (o_Busy),
        .o_Stall   (o_Stall),
        .o_Done    (o_Done),
        .o_DivZero (o_DivZero),
        .o_HI      (o_HI),
        .o_LO      (o_LO),
        .o_Result  (o_Result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Full mul/div sequence: start at E0, checks at E32, E33 (result) and E34.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int estall);
        int stalls;
        stalls  = 0;
        i_Funct = f;
        i_A     = a;
        i_B     = b;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        i_Funct = F_MFLO;
        chk({tag, " busy_after_E0"}, 64'(o_Busy), 64'd1);
        stalls += int'(o_Stall);
        repeat (32) begin
            tick;
            stalls += int'(o_Stall);
        end
        chk({tag, " busy_after_E32"}, 64'(o_Busy), 64'd1);
        chk({tag, " done_after_E32"}, 64'(o_Done), 64'd0);
        tick;
        chk({tag, " done"},    64'(o_Done),    64'd1);
        chk({tag, " idle"},    64'(o_Busy),    64'd0);
        chk({tag, " divzero"}, 64'(o_DivZero), 64'd0);
        chk({tag, " hi"},      64'(o_HI),      64'(ehi));
        chk({tag, " lo"},      64'(o_LO),      64'(elo));
        chk({tag, " stalls"},  64'(stalls),    64'(estall));
        tick;
        chk({tag, " done_pulse"}, 64'(o_Done), 64'd0);
    endtask

    task automatic write_hilo(input logic [5:0] f, input logic [31:0] a);
        i_Funct = f;
        i_A     = a;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
    endtask

    initial begin
        int seen;
        i_rst_n = 1'b0;
        i_Start = 1'b0;
        i_Req   = 1'b1;
        i_Flush = 1'b0;
        i_Funct = F_MFLO;
        i_A     = '0;
        i_B     = '0;
        repeat (2) tick;
        i_rst_n = 1'b1;
        tick;

        chk("rst busy",    64'(o_Busy),    64'd0);
        chk("rst stall",   64'(o_Stall),   64'd0);
        chk("rst done",    64'(o_Done),    64'd0);
        chk("rst divzero", 64'(o_DivZero), 64'd0);
        chk("rst hi",      64'(o_HI),      64'd0);
        chk("rst lo",      64'(o_LO),      64'd0);
        i_Req = 1'b0;

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mult_pos",  F_MULT,  32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014, 0);

`ifdef MULDIV_DIV_EN
        run_op("div_neg",    F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_intmin", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu_big",   F_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 0);

        i_Funct = F_DIVU;
        i_A     = 32'h1234;
        i_B     = 32'h0;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        chk("dz busy_E0", 64'(o_Busy), 64'd1);
        tick;
        chk("dz busy_E1", 64'(o_Busy), 64'd1);
        chk("dz done_E1", 64'(o_Done), 64'd0);
        tick;
        chk("dz done",    64'(o_Done),    64'd1);
        chk("dz divzero", 64'(o_DivZero), 64'd1);
        chk("dz idle",    64'(o_Busy),    64'd0);
        chk("dz hi",      64'(o_HI),      64'h1234);
        chk("dz lo",      64'(o_LO),      64'hFFFFFFFF);
        tick;
        chk("dz done_pulse",    64'(o_Done),    64'd0);
        chk("dz divzero_pulse", 64'(o_DivZero), 64'd0);
`else
        i_Funct = F_DIV;
        i_A     = 32'd100;
        i_B     = 32'd7;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        chk("nodiv busy", 64'(o_Busy), 64'd0);
        tick;
        chk("nodiv done",    64'(o_Done),    64'd0);
        chk("nodiv divzero", 64'(o_DivZero), 64'd0);
        chk("nodiv hi",      64'(o_HI),      64'h00000000);
        chk("nodiv lo",      64'(o_LO),      64'h00000014);
`endif

        write_hilo(F_MTLO, 32'd5);
        i_Funct = F_MFLO;
        #1;
        chk("mtlo result", 64'(o_Result), 64'd5);
        write_hilo(F_MTHI, 32'd9);
        i_Funct = F_MFHI;
        #1;
        chk("mthi result", 64'(o_Result), 64'd9);
        chk("mthi no_done", 64'(o_Done), 64'd0);

        i_Req = 1'b1;
        run_op("multu_6x7", F_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33);
        i_Funct = F_MFLO;
        #1;
        chk("mflo result", 64'(o_Result), 64'd42);
        chk("idle stall",  64'(o_Stall),  64'd0);

        // repeat run, flushed once the RUN counter reads 10
        i_Funct = F_MULTU;
        i_A     = 32'd3;
        i_B     = 32'd5;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        i_Funct = F_MFLO;
        repeat (10) tick;
        i_Flush = 1'b1;
        tick;
        i_Flush = 1'b0;
        chk("flush idle", 64'(o_Busy), 64'd0);
        seen = 0;
        repeat (30) begin
            seen += int'(o_Done);
            tick;
        end
        chk("flush no_done", 64'(seen), 64'd0);
        chk("flush lo", 64'(o_LO), 64'd42);
        chk("flush hi", 64'(o_HI), 64'd0);

        i_Flush = 1'b1;
        write_hilo(F_MTLO, 32'd99);
        i_Flush = 1'b0;
        chk("idle_flush lo",   64'(o_LO),   64'd42);
        chk("idle_flush busy", 64'(o_Busy), 64'd0);

        // asynchronous reset in the middle of a run
        write_hilo(F_MTHI, 32'h55);
        i_Funct = F_MULTU;
        i_A     = 32'd11;
        i_B     = 32'd13;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        repeat (5) tick;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst busy",  64'(o_Busy),  64'd0);
        chk("arst stall", 64'(o_Stall), 64'd0);
        chk("arst hi",    64'(o_HI),    64'd0);
        chk("arst lo",    64'(o_LO),    64'd0);
        i_rst_n = 1'b1;
        tick;
        run_op("after_rst", F_MULTU, 32'd11, 32'd13, 32'd0, 32'd143, 33);
        i_Req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
